// File: rtl/llr_frame_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : llr_frame_packer_pkg
// Purpose  : Shared decoder parameters (Decoder_Parameters block) and the
//            types/constants used by the LLR frame packer.
//            `Zc      - lifting size (LLRs per decoder word)
//            `VWidth  - decoder-side LLR width
//            frame lengths in words and the legal mode encodings.
// Revision : 1.0 - initial release
// ============================================================================

// ---- Decoder_Parameters ----------------------------------------------------
`ifndef DECODER_PARAMETERS_DEFINED
`define DECODER_PARAMETERS_DEFINED
`define Zc             64
`define VWidth         6
`define FRAME_LEN_R23  32
`define FRAME_LEN_R78  24
`define MODE_R23       2'd1
`define MODE_R78       2'd2
`endif
// ----------------------------------------------------------------------------

package llr_frame_packer_pkg;

    localparam int         c_ZC            = `Zc;
    localparam int         c_VWIDTH        = `VWidth;
    localparam int         c_FRAME_LEN_R23 = `FRAME_LEN_R23;
    localparam int         c_FRAME_LEN_R78 = `FRAME_LEN_R78;
    localparam logic [1:0] c_MODE_R23      = `MODE_R23;
    localparam logic [1:0] c_MODE_R78      = `MODE_R78;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    function automatic logic mode_legal(input logic [1:0] m);
        return (m == c_MODE_R23) || (m == c_MODE_R78);
    endfunction

    // Frame length in words; illegal modes never start a frame.
    function automatic logic [5:0] frame_len_of(input logic [1:0] m);
        return (m == c_MODE_R78) ? 6'(c_FRAME_LEN_R78) : 6'(c_FRAME_LEN_R23);
    endfunction

endpackage

`default_nettype wire

// File: rtl/llr_frame_packer_if.sv
`default_nettype none
// ============================================================================
// Module   : llr_frame_packer_if
// Purpose  : Beat-side (S_*) and word-side (W_*) handshake bundle.
//            slave  : packer view (consumes beats, produces words)
//            master : environment view
// Revision : 1.0 - initial release
// ============================================================================
interface llr_frame_packer_if #(
    parameter int LANES = 16,
    parameter int IN_W  = 8
);
    import llr_frame_packer_pkg::*;

    logic                         S_VALID;
    logic                         S_READY;
    logic [LANES*IN_W-1:0]        S_DATA;
    logic                         S_LAST;
    logic                         W_VALID;
    logic                         W_READY;
    logic                         W_LAST;
    logic [c_ZC*c_VWIDTH-1:0]     W_DATA;

    modport slave (
        input  S_VALID, S_DATA, S_LAST, W_READY,
        output S_READY, W_VALID, W_LAST, W_DATA
    );

    modport master (
        output S_VALID, S_DATA, S_LAST, W_READY,
        input  S_READY, W_VALID, W_LAST, W_DATA
    );
endinterface

`default_nettype wire

// File: rtl/llr_frame_packer_saturate.sv
`default_nettype none
// ============================================================================
// Module   : llr_saturate
// Purpose  : Combinational single-lane symmetric clipper.
//            llr_in  : signed IN_W input LLR
//            llr_out : signed OUT_W LLR clipped to +/-(2^(OUT_W-1)-1)
// Revision : 1.0 - initial release
// ============================================================================
module llr_saturate #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 6
) (
    input  logic signed [IN_W-1:0]  llr_in,
    output logic signed [OUT_W-1:0] llr_out
);
    localparam logic signed [IN_W-1:0] c_MAX = IN_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [IN_W-1:0] c_MIN = -c_MAX;

    // Symmetric range: the most negative code is never produced.
    always_comb begin
        if (llr_in > c_MAX) begin
            llr_out = OUT_W'(c_MAX);
        end else if (llr_in < c_MIN) begin
            llr_out = OUT_W'(c_MIN);
        end else begin
            llr_out = llr_in[OUT_W-1:0];
        end
    end
endmodule

`default_nettype wire

// File: rtl/llr_frame_packer.sv
`default_nettype none
// ============================================================================
// Module   : llr_frame_packer
// Purpose  : Packs LANES-wide saturated LLR beats into Zc-wide decoder words
//            and frames them (32 or 24 words) with zero-fill on early end.
// Ports    : clk, rst_n (async, active low), mode (frame length select),
//            frame_err (one-cycle framing violation pulse),
//            bus (llr_frame_packer_if.slave: S_* beats in, W_* words out)
// Revision : 1.0 - initial release
// ============================================================================
module llr_frame_packer
    import llr_frame_packer_pkg::*;
#(
    parameter int LANES = 16,
    parameter int IN_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            mode,
    output logic                  frame_err,
    llr_frame_packer_if.slave     bus
);
    localparam int c_BEATS  = c_ZC / LANES;
    localparam int c_BCW    = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
    localparam int c_SLOT_W = LANES * c_VWIDTH;
    localparam int c_WORD_W = c_ZC * c_VWIDTH;

    state_t                r_state, w_state_next;
    logic [c_BCW-1:0]      r_beat_cnt;
    logic [5:0]            r_word_cnt;
    logic [5:0]            r_frame_len;
    logic                  r_run;
    logic                  r_asm_full, r_asm_last;
    logic [c_WORD_W-1:0]   r_asm_data;
    logic [c_WORD_W-1:0]   r_out_data;
    logic                  r_out_valid, r_out_last;
    logic                  r_frame_err;

    logic [c_SLOT_W-1:0]   w_sat_beat;
    logic [c_WORD_W-1:0]   w_merged;
    logic [5:0]            w_frame_len;
    logic                  w_accept, w_beat_end, w_last_word, w_final_beat;
    logic                  w_word_done, w_frame_close, w_err;
    logic                  w_out_free, w_gen_zero, w_frame_done;

    generate
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            llr_saturate #(.IN_W(IN_W), .OUT_W(c_VWIDTH)) u_sat (
                .llr_in  (bus.S_DATA[k*IN_W +: IN_W]),
                .llr_out (w_sat_beat[k*c_VWIDTH +: c_VWIDTH])
            );
        end
    endgenerate

    // Earlier slots come from the assembly register, the current slot from
    // the incoming beat, later slots are zero (this is also the zero-fill
    // for a word cut short by S_LAST).
    always_comb begin
        w_merged = '0;
        for (int b = 0; b < c_BEATS; b++) begin
            if (c_BCW'(b) < r_beat_cnt) begin
                w_merged[b*c_SLOT_W +: c_SLOT_W] = r_asm_data[b*c_SLOT_W +: c_SLOT_W];
            end else if (c_BCW'(b) == r_beat_cnt) begin
                w_merged[b*c_SLOT_W +: c_SLOT_W] = w_sat_beat;
            end
        end
    end

    // Frame length is latched by the first beat; until then follow mode.
    assign w_frame_len   = (r_state == ST_IDLE) ? frame_len_of(mode) : r_frame_len;
    assign bus.S_READY   = r_run && (((r_state == ST_IDLE) && mode_legal(mode)) ||
                                     ((r_state == ST_FILL) && !r_asm_full));
    assign w_accept      = bus.S_VALID && bus.S_READY;
    assign w_beat_end    = (r_beat_cnt == c_BCW'(c_BEATS - 1));
    assign w_last_word   = (r_word_cnt == (w_frame_len - 6'd1));
    assign w_final_beat  = w_beat_end && w_last_word;
    assign w_word_done   = w_accept && (w_beat_end || bus.S_LAST);
    assign w_frame_close = w_word_done && (bus.S_LAST || w_last_word);
    assign w_err         = w_accept && (bus.S_LAST ? !w_final_beat : w_final_beat);
    assign w_out_free    = !r_out_valid || bus.W_READY;
    assign w_gen_zero    = (r_state == ST_DRAIN) && !r_asm_full && (r_word_cnt != r_frame_len);
    assign w_frame_done  = r_out_valid && bus.W_READY && r_out_last;

    assign bus.W_VALID   = r_out_valid;
    assign bus.W_LAST    = r_out_last;
    assign bus.W_DATA    = r_out_data;
    assign frame_err     = r_frame_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_FILL: begin
                if (w_accept) begin
                    w_state_next = w_frame_close ? ST_DRAIN : ST_FILL;
                end
            end
            ST_DRAIN: begin
                if (w_frame_done) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run       <= 1'b0;
            r_beat_cnt  <= '0;
            r_word_cnt  <= '0;
            r_frame_len <= '0;
            r_asm_full  <= 1'b0;
            r_asm_last  <= 1'b0;
            r_asm_data  <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_run       <= 1'b1;
            r_frame_err <= w_err;

            // Assembly side: accept beats, or synthesise zero words in DRAIN.
            if (w_accept) begin
                r_asm_data <= w_merged;
                if (r_state == ST_IDLE) begin
                    r_frame_len <= frame_len_of(mode);
                end
                if (w_word_done) begin
                    r_beat_cnt <= '0;
                    r_word_cnt <= r_word_cnt + 6'd1;
                    if (!w_out_free) begin
                        r_asm_full <= 1'b1;
                        r_asm_last <= w_last_word;
                    end
                end else begin
                    r_beat_cnt <= r_beat_cnt + c_BCW'(1);
                end
            end else if (w_gen_zero) begin
                r_asm_data <= '0;
                r_asm_full <= 1'b1;
                r_asm_last <= (r_word_cnt == (r_frame_len - 6'd1));
                r_word_cnt <= r_word_cnt + 6'd1;
            end

            // Output side: a parked word has priority; a word completing this
            // cycle bypasses the assembly register when the output is free.
            if (w_out_free) begin
                if (r_asm_full) begin
                    r_out_data  <= r_asm_data;
                    r_out_valid <= 1'b1;
                    r_out_last  <= r_asm_last;
                    r_asm_full  <= 1'b0;
                end else if (w_word_done) begin
                    r_out_data  <= w_merged;
                    r_out_valid <= 1'b1;
                    r_out_last  <= w_last_word;
                end else if (r_out_valid) begin
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                end
            end

            if (w_frame_done) begin
                r_word_cnt <= '0;
                r_beat_cnt <= '0;
            end
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_llr_frame_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_llr_frame_packer
// Purpose  : Directed self-checking bench for llr_frame_packer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_llr_frame_packer;
    import llr_frame_packer_pkg::*;

    localparam int c_LANES = 16;
    localparam int c_IN_W  = 8;
    localparam int c_BEATS = c_ZC / c_LANES;
    localparam int c_WW    = c_ZC * c_VWIDTH;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] mode = 2'd1;
    logic       frame_err;

    always #5 clk = ~clk;

    llr_frame_packer_if #(.LANES(c_LANES), .IN_W(c_IN_W)) bus ();

    llr_frame_packer #(.LANES(c_LANES), .IN_W(c_IN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .frame_err (frame_err),
        .bus       (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int err_cnt = 0;
    int unstable = 0;
    int acc_total = 0;

    logic [c_WW-1:0] rx_data[$];
    logic            rx_last[$];

    logic            p_valid = 1'b0;
    logic            p_ready = 1'b0;
    logic            p_last = 1'b0;
    logic [c_WW-1:0] p_data = '0;

    // Observer: records word transfers, accepted beats, error pulses, and
    // any change of the word side while it is stalled.
    always @(negedge clk) begin
        if (!rst_n) begin
            p_valid = 1'b0;
        end else begin
            if (p_valid && !p_ready &&
                (!bus.W_VALID || bus.W_DATA !== p_data || bus.W_LAST !== p_last))
                unstable++;
            if (bus.W_VALID && bus.W_READY) begin
                rx_data.push_back(bus.W_DATA);
                rx_last.push_back(bus.W_LAST);
            end
            if (bus.S_VALID && bus.S_READY) acc_total++;
            if (frame_err) err_cnt++;
            p_valid = bus.W_VALID;
            p_ready = bus.W_READY;
            p_last  = bus.W_LAST;
            p_data  = bus.W_DATA;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [c_WW-1:0] obs, input logic [c_WW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Stimulus patterns: 0 = 0..63 repeating, 1 = +127/-128 by lane parity,
    // 2 = in-range values that differ from word to word.
    function automatic int lane_val(input int pat, input int w, input int b, input int k);
        case (pat)
            0:       return (w * c_ZC + b * c_LANES + k) % 64;
            1:       return (k % 2 == 0) ? 127 : -128;
            default: return ((w * 7 + b * 3 + k) % 61) - 30;
        endcase
    endfunction

    function automatic logic [c_VWIDTH-1:0] sat_model(input int v);
        int m;
        m = (1 << (c_VWIDTH - 1)) - 1;
        if (v > m) v = m;
        else if (v < -m) v = -m;
        return c_VWIDTH'(v);
    endfunction

    function automatic logic [c_LANES*c_IN_W-1:0] beat_data(input int pat, input int w, input int b);
        logic [c_LANES*c_IN_W-1:0] d;
        d = '0;
        for (int k = 0; k < c_LANES; k++) d[k*c_IN_W +: c_IN_W] = c_IN_W'(lane_val(pat, w, b, k));
        return d;
    endfunction

    function automatic logic [c_WW-1:0] exp_word(input int pat, input int w, input int vb);
        logic [c_WW-1:0] e;
        e = '0;
        for (int b = 0; b < c_BEATS; b++)
            for (int k = 0; k < c_LANES; k++)
                if (b < vb) e[(b*c_LANES+k)*c_VWIDTH +: c_VWIDTH] = sat_model(lane_val(pat, w, b, k));
        return e;
    endfunction

    task automatic push_beat(input logic [c_LANES*c_IN_W-1:0] d, input logic l);
        bit acc;
        int guard;
        acc = 1'b0;
        guard = 0;
        bus.S_VALID = 1'b1;
        bus.S_DATA  = d;
        bus.S_LAST  = l;
        while (!acc && guard < 200) begin
            @(negedge clk);
            acc = bus.S_READY;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!acc) chk_int("beat_accept_timeout", guard, -1);
    endtask

    task automatic send_range(input int pat, input int j0, input int j1, input int last_at);
        for (int j = j0; j <= j1; j++)
            push_beat(beat_data(pat, j / c_BEATS, j % c_BEATS), j == last_at);
    endtask

    task automatic idle_inputs();
        bus.S_VALID = 1'b0;
        bus.S_LAST  = 1'b0;
    endtask

    task automatic clear_rx();
        rx_data.delete();
        rx_last.delete();
    endtask

    task automatic wait_words(input string tag, input int n);
        int g;
        g = 0;
        while (rx_data.size() < n && g < 600) begin
            @(posedge clk);
            #1;
            g++;
        end
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        chk_int($sformatf("%s_word_count", tag), rx_data.size(), n);
    endtask

    // Words below good_w are full; word good_w keeps part_b beats; the rest zero.
    task automatic check_frame(input string tag, input int pat, input int n, input int good_w, input int part_b);
        logic [c_WW-1:0] obs;
        logic            obs_last;
        int              vb;
        for (int w = 0; w < n; w++) begin
            obs      = (w < rx_data.size()) ? rx_data[w] : 'x;
            obs_last = (w < rx_last.size()) ? rx_last[w] : 1'bx;
            vb = (w < good_w) ? c_BEATS : ((w == good_w) ? part_b : 0);
            chk($sformatf("%s_data_w%0d", tag, w), obs, exp_word(pat, w, vb));
            chk_bit($sformatf("%s_last_w%0d", tag, w), obs_last, (w == n - 1));
        end
    endtask

    initial begin
        int e0, u0, a0, cnt_rdy, cnt_wv;

        bus.S_VALID = 1'b0;
        bus.S_LAST  = 1'b0;
        bus.S_DATA  = '0;
        bus.W_READY = 1'b1;

        // Reset state
        #2;
        chk_bit("rst_s_ready", bus.S_READY, 1'b0);
        chk_bit("rst_w_valid", bus.W_VALID, 1'b0);
        chk_bit("rst_w_last", bus.W_LAST, 1'b0);
        chk_bit("rst_frame_err", frame_err, 1'b0);
        chk("rst_w_data", bus.W_DATA, '0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk_bit("ready_release_cycle", bus.S_READY, 1'b0);
        @(posedge clk);
        #1;
        chk_bit("ready_after_release", bus.S_READY, 1'b1);

        // Rate 2/3 ramp, latency to first word
        clear_rx();
        e0 = err_cnt;
        mode = 2'd1;
        send_range(0, 0, 2, -1);
        chk_bit("t1_wvalid_before_word", bus.W_VALID, 1'b0);
        send_range(0, 3, 3, -1);
        chk_bit("t1_wvalid_after_word", bus.W_VALID, 1'b1);
        send_range(0, 4, 127, 127);
        idle_inputs();
        wait_words("t1", 32);
        check_frame("t1", 0, 32, 32, 0);
        chk_int("t1_frame_err", err_cnt - e0, 0);

        // Rate 7/8 saturation extremes, mode changed mid-frame (ignored)
        clear_rx();
        e0 = err_cnt;
        mode = 2'd2;
        send_range(1, 0, 9, -1);
        mode = 2'd1;
        send_range(1, 10, 95, 95);
        idle_inputs();
        mode = 2'd2;
        wait_words("t2", 24);
        check_frame("t2", 1, 24, 24, 0);
        chk_int("t2_frame_err", err_cnt - e0, 0);

        // Word-side stall for 20 cycles mid-frame
        clear_rx();
        u0 = unstable;
        a0 = 0;
        mode = 2'd1;
        fork
            begin
                send_range(2, 0, 127, 127);
                idle_inputs();
            end
            begin : b_stall
                int g;
                g = 0;
                while (rx_data.size() < 5 && g < 300) begin
                    @(posedge clk);
                    #1;
                    g++;
                end
                bus.W_READY = 1'b0;
                a0 = acc_total;
                repeat (20) begin
                    @(posedge clk);
                    #1;
                end
                @(negedge clk);
                chk_bit("t3_s_ready_stalled", bus.S_READY, 1'b0);
                chk_bit("t3_w_valid_stalled", bus.W_VALID, 1'b1);
                chk_int("t3_beats_in_stall_le8", int'(acc_total - a0 <= 2 * c_BEATS), 1);
                @(posedge clk);
                #1;
                bus.W_READY = 1'b1;
            end
        join
        wait_words("t3", 32);
        check_frame("t3", 2, 32, 32, 0);
        chk_int("t3_unstable", unstable - u0, 0);

        // Early S_LAST on beat 50: word 12 keeps 3 beats, zero words follow
        clear_rx();
        e0 = err_cnt;
        mode = 2'd1;
        send_range(2, 0, 50, 50);
        idle_inputs();
        wait_words("t4", 32);
        check_frame("t4", 2, 32, 12, 3);
        chk_int("t4_frame_err", err_cnt - e0, 1);

        // Missing S_LAST on the final beat of a rate 7/8 frame
        clear_rx();
        e0 = err_cnt;
        mode = 2'd2;
        send_range(2, 0, 95, -1);
        idle_inputs();
        wait_words("t7", 24);
        check_frame("t7", 2, 24, 24, 0);
        chk_int("t7_frame_err", err_cnt - e0, 1);

        // Reset in the middle of word 10
        mode = 2'd1;
        send_range(2, 0, 41, -1);
        rst_n = 1'b0;
        idle_inputs();
        #1;
        chk_bit("t5_rst_s_ready", bus.S_READY, 1'b0);
        chk_bit("t5_rst_w_valid", bus.W_VALID, 1'b0);
        chk_bit("t5_rst_w_last", bus.W_LAST, 1'b0);
        chk_bit("t5_rst_frame_err", frame_err, 1'b0);
        chk("t5_rst_w_data", bus.W_DATA, '0);
        repeat (3) @(posedge clk);
        #1;
        clear_rx();
        e0 = err_cnt;
        mode = 2'd2;
        rst_n = 1'b1;
        @(negedge clk);
        chk_bit("t5_ready_release_cycle", bus.S_READY, 1'b0);
        @(posedge clk);
        #1;
        chk_bit("t5_ready_after_release", bus.S_READY, 1'b1);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        chk_int("t5_no_stale_words", rx_data.size(), 0);
        send_range(1, 0, 95, 95);
        idle_inputs();
        wait_words("t5", 24);
        check_frame("t5", 1, 24, 24, 0);
        chk_int("t5_frame_err", err_cnt - e0, 0);

        // Illegal mode in IDLE
        clear_rx();
        mode = 2'd3;
        bus.S_VALID = 1'b1;
        bus.S_DATA  = beat_data(2, 0, 0);
        cnt_rdy = 0;
        cnt_wv  = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.S_READY) cnt_rdy++;
            if (bus.W_VALID) cnt_wv++;
        end
        idle_inputs();
        chk_int("t6_s_ready_mode3", cnt_rdy, 0);
        chk_int("t6_w_valid_mode3", cnt_wv, 0);
        chk_int("t6_words_mode3", rx_data.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

`default_nettype wire
